// File: rtl/fp_add_issue.sv
// Issue/collect stage around a combinational FP32 adder: in-order request FIFO,
// rounding-mode resolution and screening, registered valid/ready response slot.
// Optional define FP_ADD_ISSUE_BYPASS_EN lets a request skip an empty FIFO.
module fp_add_issue #(
  parameter int         DEPTH     = 4,
  parameter logic [2:0] FRM_RESET = 3'b000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [31:0]                  req_a,
  input  logic [31:0]                  req_b,
  input  logic [2:0]                   req_rm,
  input  logic [3:0]                   req_tag,
  input  logic                         frm_we,
  input  logic [2:0]                   frm_wdata,
  output logic [2:0]                   frm,
  output logic [31:0]                  fp_a,
  output logic [31:0]                  fp_b,
  output logic [2:0]                   r_mode,
  input  logic [31:0]                  fp_result,
  input  logic                         overflow,
  input  logic                         underflow,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [31:0]                  rsp_result,
  output logic [3:0]                   rsp_tag,
  output logic [2:0]                   rsp_flags,
  output logic [2:0]                   fflags_acc,
  input  logic                         fflags_clr,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
    logic        ill;
    logic [3:0]  tag;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wrPtr_q, rdPtr_q;
  logic [OW-1:0]   occ_q, occ_d;
  logic [2:0]      frm_q;
  logic            rspValid_q, rspValid_d;
  logic [31:0]     rspResult_q, rspResult_d;
  logic [3:0]      rspTag_q, rspTag_d;
  logic [2:0]      rspFlags_q, rspFlags_d;
  logic [2:0]      fflags_q, fflags_d;

  logic [2:0]      effRm;
  logic            reqIllegal, fifoEmpty, slotFree, accept;
  logic            bypass, capture, push, pop;
  entry_t          reqEntry, srcEntry;

  always_comb begin
    effRm      = (req_rm == 3'b111) ? frm_q : req_rm;
    reqIllegal = (effRm >= 3'b101);
    reqEntry   = '{a: req_a, b: req_b, rm: (reqIllegal ? 3'b000 : effRm),
                   ill: reqIllegal, tag: req_tag};
    fifoEmpty  = (occ_q == '0);
    slotFree   = !rspValid_q || rsp_ready;
    req_ready  = (occ_q < DEPTH_C);
    accept     = req_valid && req_ready;
`ifdef FP_ADD_ISSUE_BYPASS_EN
    bypass     = fifoEmpty && slotFree && req_valid;
`else
    bypass     = 1'b0;
`endif
    srcEntry   = bypass ? reqEntry : mem_q[rdPtr_q];
    capture    = slotFree && (!fifoEmpty || bypass);
    push       = accept && !bypass;
    pop        = capture && !fifoEmpty;
    occ_d      = occ_q + OW'(push) - OW'(pop);
  end

  always_comb begin
    fp_a   = 32'h0;
    fp_b   = 32'h0;
    r_mode = 3'b000;
    if (bypass || !fifoEmpty) begin
      fp_a   = srcEntry.a;
      fp_b   = srcEntry.b;
      r_mode = srcEntry.rm;
    end
  end

  // Slot reloads whenever it is free or being drained, giving one result per cycle.
  always_comb begin
    rspValid_d  = rspValid_q;
    rspResult_d = rspResult_q;
    rspTag_d    = rspTag_q;
    rspFlags_d  = rspFlags_q;
    if (capture) begin
      rspValid_d  = 1'b1;
      rspTag_d    = srcEntry.tag;
      rspResult_d = srcEntry.ill ? 32'h7fc00000 : fp_result;
      rspFlags_d  = srcEntry.ill ? 3'b100 : {1'b0, overflow, underflow};
    end else if (rsp_ready) begin
      rspValid_d  = 1'b0;
    end
    fflags_d = (fflags_clr ? 3'b000 : fflags_q) |
               ((rspValid_q && rsp_ready) ? rspFlags_q : 3'b000);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      occ_q       <= '0;
      frm_q       <= FRM_RESET;
      rspValid_q  <= 1'b0;
      rspResult_q <= 32'h0;
      rspTag_q    <= 4'h0;
      rspFlags_q  <= 3'b000;
      fflags_q    <= 3'b000;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + PW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
      occ_q       <= occ_d;
      if (frm_we) frm_q <= frm_wdata;
      rspValid_q  <= rspValid_d;
      rspResult_q <= rspResult_d;
      rspTag_q    <= rspTag_d;
      rspFlags_q  <= rspFlags_d;
      fflags_q    <= fflags_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= reqEntry;
  end

  assign frm        = frm_q;
  assign rsp_valid  = rspValid_q;
  assign rsp_result = rspResult_q;
  assign rsp_tag    = rspTag_q;
  assign rsp_flags  = rspFlags_q;
  assign fflags_acc = fflags_q;
  assign occupancy  = occ_q;

endmodule

// File: tb/tb_fp_add_issue.sv
// Scoreboard bench for fp_add_issue: directed requests push expected responses,
// a negedge monitor pops and compares at every response handshake.
module tb_fp_add_issue;

  localparam int DEPTH = 4;
`ifdef FP_ADD_ISSUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0, req_b = '0;
  logic [2:0]  req_rm = '0;
  logic [3:0]  req_tag = '0;
  logic        frm_we = 1'b0;
  logic [2:0]  frm_wdata = '0;
  logic [2:0]  frm;
  logic [31:0] fp_a, fp_b;
  logic [2:0]  r_mode;
  logic [31:0] fp_result;
  logic        overflow, underflow;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic [2:0]  rsp_flags;
  logic [2:0]  fflags_acc;
  logic        fflags_clr = 1'b0;
  logic [2:0]  occupancy;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
    logic [2:0]  flags;
  } exp_t;

  exp_t       sbQ[$];
  int         checks = 0;
  int         errors = 0;
  logic [2:0] frmModel = 3'b000;

  fp_add_issue #(.DEPTH(DEPTH), .FRM_RESET(3'b000)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm), .req_tag(req_tag),
    .frm_we(frm_we), .frm_wdata(frm_wdata), .frm(frm),
    .fp_a(fp_a), .fp_b(fp_b), .r_mode(r_mode),
    .fp_result(fp_result), .overflow(overflow), .underflow(underflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_flags(rsp_flags),
    .fflags_acc(fflags_acc), .fflags_clr(fflags_clr), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Adder stand-in: real sums for a few known pairs, otherwise a marker value
  // whose low three bits are the rounding mode the adder was handed.
  function automatic logic [33:0] adderStub(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] rm);
    if (a == 32'h3f800000 && b == 32'h3f800000) return {32'h40000000, 2'b00};
    if (a == 32'h7f7fffff && b == 32'h7f7fffff)
      return {((rm == 3'b001 || rm == 3'b010) ? 32'h7f7fffff : 32'h7f800000), 2'b10};
    if (a == 32'h00800001 && b == 32'h80800000) return {32'h00000001, 2'b01};
    return {a[31:3] ^ b[31:3], rm, 2'b00};
  endfunction

  assign {fp_result, overflow, underflow} = adderStub(fp_a, fp_b, r_mode);

  function automatic exp_t expectedOf(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] rm, input logic [3:0] tag);
    logic [2:0]  eff;
    logic [33:0] s;
    eff = (rm == 3'b111) ? frmModel : rm;
    if (eff >= 3'b101) return '{res: 32'h7fc00000, tag: tag, flags: 3'b100};
    s = adderStub(a, b, eff);
    return '{res: s[33:2], tag: tag, flags: {1'b0, s[1:0]}};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm,
                               input logic [3:0] tag, output logic acc);
    req_valid = 1'b1;
    req_a = a; req_b = b; req_rm = rm; req_tag = tag;
    acc = req_ready;
    if (acc) sbQ.push_back(expectedOf(a, b, rm, tag));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sbQ.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain", sbQ.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      checks++;
      if (sbQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_rsp: got tag %h result %h, queue empty", rsp_tag, rsp_result);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        if (rsp_result !== e.res || rsp_tag !== e.tag || rsp_flags !== e.flags) begin
          errors++;
          $display("[TB] FAIL response: got tag %h result %h flags %b expected tag %h result %h flags %b",
                   rsp_tag, rsp_result, rsp_flags, e.tag, e.res, e.flags);
        end
      end
    end
  end

  initial begin
    logic acc;
    int   accCount, edges;

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_occupancy", occupancy, 0);
    checkOutput("reset_frm", frm, 0);
    checkOutput("reset_fflags", fflags_acc, 0);
    checkOutput("reset_req_ready", req_ready, 1);
    #9 rst = 1'b0;
    @(posedge clk); #1;

    // Basic add with latency measurement
    rsp_ready = 1'b1;
    applyStimulus(32'h3f800000, 32'h3f800000, 3'b001, 4'd5, acc);
    edges = 1;
    while (!rsp_valid && edges < 8) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput("latency", edges, LAT);
    waitDrain();

    // Backpressure: fill FIFO plus slot, then drain one per cycle
    rsp_ready = 1'b0;
    accCount = 0;
    for (int t = 0; t < 7; t++) begin
      applyStimulus(32'h10000000 | (t << 8), 32'h0, 3'b000, 4'(t), acc);
      if (acc) accCount++;
    end
    checkOutput("bp_accepted", accCount, 5);
    checkOutput("bp_req_ready", req_ready, 0);
    checkOutput("bp_occupancy", occupancy, 4);
    checkOutput("bp_rsp_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("bp_drained", sbQ.size(), 0);
    checkOutput("bp_rsp_idle", rsp_valid, 0);
    checkOutput("bp_occ_zero", occupancy, 0);

    // Dynamic rounding: same-cycle frm write is not seen by that request
    frm_we = 1'b1; frm_wdata = 3'b011;
    applyStimulus(32'h12345678, 32'h0, 3'b111, 4'd7, acc);
    frm_we = 1'b0; frmModel = 3'b011;
    checkOutput("frm_written", frm, 3'b011);
    applyStimulus(32'h12345678, 32'h0, 3'b111, 4'd8, acc);
    waitDrain();
    checkOutput("fflags_clean", fflags_acc, 3'b000);

    // Illegal static rounding mode
    applyStimulus(32'h40000000, 32'h3f800000, 3'b101, 4'd9, acc);
    waitDrain();
    checkOutput("fflags_illegal", fflags_acc, 3'b100);

    // Illegal frm value stored as written, then used dynamically
    frm_we = 1'b1; frm_wdata = 3'b110;
    @(posedge clk); #1;
    frm_we = 1'b0; frmModel = 3'b110;
    checkOutput("frm_illegal_stored", frm, 3'b110);
    applyStimulus(32'h22222220, 32'h0, 3'b111, 4'd3, acc);
    waitDrain();

    // Clear coinciding with an overflow handshake keeps the new flag
    applyStimulus(32'h7f7fffff, 32'h7f7fffff, 3'b001, 4'd10, acc);
    edges = 0;
    while (!rsp_valid && edges < 8) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput("ovf_rsp_seen", rsp_valid, 1);
    fflags_clr = 1'b1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    checkOutput("fflags_clr_set", fflags_acc, 3'b010);

    // Underflow flag path
    applyStimulus(32'h00800001, 32'h80800000, 3'b000, 4'd11, acc);
    waitDrain();
    checkOutput("fflags_unf", fflags_acc, 3'b011);

    // Reset mid-operation discards queued and held entries
    rsp_ready = 1'b0;
    applyStimulus(32'h30000000, 32'h0, 3'b010, 4'd1, acc);
    applyStimulus(32'h31000000, 32'h0, 3'b010, 4'd2, acc);
    applyStimulus(32'h32000000, 32'h0, 3'b010, 4'd4, acc);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_occupancy", occupancy, 0);
    checkOutput("midrst_rsp_valid", rsp_valid, 0);
    checkOutput("midrst_frm", frm, 3'b000);
    checkOutput("midrst_fflags", fflags_acc, 3'b000);
    sbQ.delete();
    frmModel = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    applyStimulus(32'h3f800000, 32'h3f800000, 3'b111, 4'd12, acc);
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
